scr1_vec_banked_memory: RTL and testbench

Parametrised successor to the core's dual-port TCM: a LANES-way word-interleaved banked SRAM.
- Port A is a read-only scalar port for instruction fetch.
- Port B is a read/write port for scalar or full-vector (LANES consecutive words) data access, with per-lane byte enables.
- Adds valid/ready handshakes, bank-conflict arbitration with an anti-starvation counter, any-word-aligned unaligned vector access and address wrap-around.
- Sits between the core's IMEM/DMEM routers and the vector unit.

---
 rtl/scr1_vec_banked_memory.sv | 149 ++++++++++++++
 tb/tb_scr1_vec_banked_memory.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_vec_banked_memory.sv
// LANES-way word-interleaved banked SRAM: scalar fetch port A, scalar/vector
// read-write port B, bank-conflict arbitration with anti-starvation for A.
module scr1_vec_banked_memory #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LANES      = 8,
    parameter int unsigned SIZE       = 65536,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            a_req,
    output logic                            a_ready,
    input  logic [$clog2(SIZE)-3:0]         a_addr,
    output logic [WIDTH-1:0]                a_rdata,
    output logic                            a_rvalid,
    input  logic                            b_req,
    output logic                            b_ready,
    input  logic                            b_we,
    input  logic                            b_vec,
    input  logic [$clog2(SIZE)-3:0]         b_addr,
    input  logic [LANES*(WIDTH/8)-1:0]      b_be,
    input  logic [LANES*WIDTH-1:0]          b_wdata,
    output logic [LANES*WIDTH-1:0]          b_rdata,
    output logic                            b_rvalid
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned WORDS  = SIZE / NBYTES;
    localparam int unsigned WAW    = $clog2(WORDS);
    localparam int unsigned LB     = $clog2(LANES);
    localparam int unsigned ROWS   = WORDS / LANES;
    localparam int unsigned SW     = $clog2(STARVE_MAX + 1);

    logic [WIDTH-1:0]       mem_q [LANES][ROWS];

    logic [WAW-1:0]         a_word;
    logic [WAW-1:0]         b_word;
    logic [LB-1:0]          a_bank;
    logic [LB-1:0]          b_bank;
    logic                   overlap_c;
    logic                   a_prio_c;

    logic [WAW-LB-1:0]      bank_row_c   [LANES];
    logic                   bank_we_c    [LANES];
    logic [NBYTES-1:0]      bank_be_c    [LANES];
    logic [WIDTH-1:0]       bank_wdata_c [LANES];

    logic [WIDTH-1:0]       a_rd_c;
    logic [LANES*WIDTH-1:0] b_rd_c;

    logic                   a_rvalid_q, a_rvalid_d;
    logic                   b_rvalid_q, b_rvalid_d;
    logic [WIDTH-1:0]       a_rdata_q, a_rdata_d;
    logic [LANES*WIDTH-1:0] b_rdata_q, b_rdata_d;
    logic [SW-1:0]          starve_q, starve_d;

    assign a_word = WAW'(a_addr);
    assign b_word = WAW'(b_addr);
    assign a_bank = a_word[LB-1:0];
    assign b_bank = b_word[LB-1:0];

    // Conflict detection: a vector B access occupies every bank.
    assign overlap_c = a_req & b_req & (b_vec | (a_bank == b_bank));
    assign a_prio_c  = (starve_q == SW'(STARVE_MAX));
    assign a_ready   = rst_n & a_req & (~overlap_c | a_prio_c);
    assign b_ready   = rst_n & b_req & (~overlap_c | ~a_prio_c);

    // Per-bank write steering: bank b serves lane (b - b_addr) mod LANES.
    always_comb begin
        logic [LB-1:0]  li;
        logic [WAW-1:0] wsum;
        li   = '0;
        wsum = '0;
        for (int unsigned b = 0; b < LANES; b++) begin
            li              = LB'(LB'(b) - b_bank);
            wsum            = b_word + WAW'(li);
            bank_row_c[b]   = wsum[WAW-1:LB];
            bank_we_c[b]    = b_ready & b_we & (b_vec | (LB'(b) == b_bank));
            bank_be_c[b]    = b_be[li*NBYTES +: NBYTES];
            bank_wdata_c[b] = b_wdata[li*WIDTH +: WIDTH];
        end
    end

    // Read muxing: vector lanes walk consecutive words, scalar replicates.
    always_comb begin
        logic [WAW-1:0] w;
        w      = '0;
        a_rd_c = mem_q[a_bank][a_word[WAW-1:LB]];
        b_rd_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w = b_vec ? (b_word + WAW'(i)) : b_word;
            b_rd_c[i*WIDTH +: WIDTH] = mem_q[w[LB-1:0]][w[WAW-1:LB]];
        end
    end

    // Storage array with byte-granular writes; contents are not reset.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < LANES; b++) begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
                if (bank_we_c[b] && bank_be_c[b][k]) begin
                    mem_q[b][bank_row_c[b]][k*8 +: 8] <= bank_wdata_c[b][k*8 +: 8];
                end
            end
        end
    end

    // Response and starvation-counter next state.
    always_comb begin
        a_rvalid_d = a_ready;
        b_rvalid_d = b_ready & ~b_we;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        starve_d   = starve_q;
        if (a_ready) begin
            a_rdata_d = a_rd_c;
        end
        if (b_ready && !b_we) begin
            b_rdata_d = b_rd_c;
        end
        if (!a_req || a_ready) begin
            starve_d = '0;
        end else if (!a_prio_c) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            starve_q   <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            starve_q   <= starve_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_scr1_vec_banked_memory.sv
// Self-checking bench for scr1_vec_banked_memory (default parameters).
module tb_scr1_vec_banked_memory;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned LANES = 8;
    localparam int unsigned SIZE  = 65536;
    localparam int unsigned WORDS = SIZE / 4;
    localparam int unsigned WA    = 14;
    localparam int unsigned VW    = LANES * WIDTH;
    localparam int unsigned BEW   = LANES * 4;

    typedef struct {
        logic          a_req;
        logic [WA-1:0] a_addr;
        logic          b_req;
        logic          b_we;
        logic          b_vec;
        logic [WA-1:0] b_addr;
        logic [BEW-1:0] b_be;
        logic [VW-1:0] b_wdata;
        logic          exp_ar;
        logic          exp_br;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            a_req, a_ready, a_rvalid;
    logic [WA-1:0]   a_addr;
    logic [WIDTH-1:0] a_rdata;
    logic            b_req, b_ready, b_we, b_vec, b_rvalid;
    logic [WA-1:0]   b_addr;
    logic [BEW-1:0]  b_be;
    logic [VW-1:0]   b_wdata, b_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    logic [WIDTH-1:0] ref_mem [WORDS];
    logic [WIDTH-1:0] qa [$];
    logic [VW-1:0]    qb [$];
    logic [WIDTH-1:0] last_a;
    logic [VW-1:0]    last_b;
    vec_t             tbl [$];

    scr1_vec_banked_memory #(
        .WIDTH(WIDTH), .LANES(LANES), .SIZE(SIZE), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_ready(a_ready), .a_addr(a_addr),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_ready(b_ready), .b_we(b_we), .b_vec(b_vec),
        .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_rvalid(b_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] ramp(input logic [31:0] base);
        logic [VW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = base + 32'(i);
        return r;
    endfunction

    function automatic vec_t mk(input logic ar, input logic [WA-1:0] aa,
                                input logic br, input logic bw, input logic bv,
                                input logic [WA-1:0] ba, input logic [BEW-1:0] be,
                                input logic [VW-1:0] wd, input logic ear, input logic ebr);
        vec_t v;
        v.a_req = ar; v.a_addr = aa; v.b_req = br; v.b_we = bw; v.b_vec = bv;
        v.b_addr = ba; v.b_be = be; v.b_wdata = wd; v.exp_ar = ear; v.exp_br = ebr;
        return v;
    endfunction

    function automatic logic [VW-1:0] model_b_read(input logic vec, input logic [WA-1:0] addr);
        logic [VW-1:0] r;
        int w;
        for (int i = 0; i < LANES; i++) begin
            w = (int'(addr) + (vec ? i : 0)) % WORDS;
            r[i*WIDTH +: WIDTH] = ref_mem[w];
        end
        return r;
    endfunction

    task automatic model_b_write(input logic vec, input logic [WA-1:0] addr,
                                 input logic [BEW-1:0] be, input logic [VW-1:0] wd);
        int w;
        for (int i = 0; i < (vec ? LANES : 1); i++) begin
            w = (int'(addr) + i) % WORDS;
            for (int k = 0; k < 4; k++)
                if (be[i*4 + k]) ref_mem[w][k*8 +: 8] = wd[i*WIDTH + k*8 +: 8];
        end
    endtask

    task automatic check_resp();
        logic [WIDTH-1:0] ea;
        logic [VW-1:0]    eb;
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_rvalid", VW'(a_rvalid), VW'(1'b1));
            chk("a_rdata", VW'(a_rdata), VW'(ea));
            last_a = ea;
        end else begin
            chk("a_rvalid_idle", VW'(a_rvalid), VW'(1'b0));
            chk("a_rdata_hold", VW'(a_rdata), VW'(last_a));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_rvalid", VW'(b_rvalid), VW'(1'b1));
            chk("b_rdata", b_rdata, eb);
            last_b = eb;
        end else begin
            chk("b_rvalid_idle", VW'(b_rvalid), VW'(1'b0));
            chk("b_rdata_hold", b_rdata, last_b);
        end
    endtask

    task automatic drive(input vec_t v);
        a_req = v.a_req; a_addr = v.a_addr;
        b_req = v.b_req; b_we = v.b_we; b_vec = v.b_vec; b_addr = v.b_addr;
        b_be = v.b_be; b_wdata = v.b_wdata;
    endtask

    // Apply one cycle: check handshakes, push expected results, check responses.
    task automatic do_cycle(input vec_t v);
        drive(v);
        #2;
        chk("a_ready", VW'(a_ready), VW'(v.exp_ar));
        chk("b_ready", VW'(b_ready), VW'(v.exp_br));
        if (v.exp_ar) qa.push_back(ref_mem[v.a_addr]);
        if (v.exp_br && !v.b_we) qb.push_back(model_b_read(v.b_vec, v.b_addr));
        if (v.exp_br && v.b_we) model_b_write(v.b_vec, v.b_addr, v.b_be, v.b_wdata);
        @(posedge clk);
        #1;
        check_resp();
    endtask

    localparam logic [BEW-1:0] ALL = '1;
    localparam logic [WA-1:0]  TOP = WA'(WORDS - 3);

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        last_a = '0;
        last_b = '0;

        // Reset state with both requests asserted.
        rst_n = 1'b0;
        drive(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
        #2;
        chk("rst_a_ready", VW'(a_ready), '0);
        chk("rst_b_ready", VW'(b_ready), '0);
        chk("rst_a_rvalid", VW'(a_rvalid), '0);
        chk("rst_b_rvalid", VW'(b_rvalid), '0);
        chk("rst_a_rdata", VW'(a_rdata), '0);
        chk("rst_b_rdata", b_rdata, '0);
        repeat (2) @(posedge clk);
        #1;
        drive(idle);
        rst_n = 1'b1;

        // Vector write/read at 0x10.
        tbl.push_back(mk(0, 0, 1, 1, 1, 14'h10, ALL, ramp(32'hA0), 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 14'h10, 0, 0, 0, 1));
        // Wrap-around vector write, then scalar reads through the top of memory.
        tbl.push_back(mk(0, 0, 1, 1, 1, TOP, ALL, ramp(32'h100), 0, 1));
        for (int i = 0; i < LANES; i++)
            tbl.push_back(mk(1, WA'(int'(TOP) + i), 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, TOP, 0, 0, 0, 1));
        // Partial byte-enable scalar write over a known word.
        tbl.push_back(mk(0, 0, 1, 1, 0, 14'd5, ALL, VW'(32'h11111111), 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 14'd5, BEW'(4'b0101), VW'(32'hDEADBEEF), 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 14'd5, 0, 0, 0, 1));
        // A read of word 1 alongside B scalar write to word 2 (different banks).
        tbl.push_back(mk(1, 14'd1, 1, 1, 0, 14'd2, ALL, VW'(32'hCAFE0002), 1, 1));
        tbl.push_back(mk(1, 14'd9, 1, 0, 0, 14'd2, 0, 0, 1, 1));
        // Scalar conflict on bank 2: B wins, A retries next cycle.
        tbl.push_back(mk(1, 14'd10, 1, 0, 0, 14'd2, 0, 0, 0, 1));
        tbl.push_back(mk(1, 14'd10, 0, 0, 0, 0, 0, 0, 1, 0));
        foreach (tbl[i]) do_cycle(tbl[i]);

        // Starvation: A held on word 2 against continuous vector B reads.
        for (int i = 0; i < 4; i++)
            do_cycle(mk(1, 14'd2, 1, 0, 1, WA'(14'h20 + i), 0, 0, 0, 1));
        do_cycle(mk(1, 14'd2, 1, 0, 1, 14'h28, 0, 0, 1, 0));
        do_cycle(mk(0, 0, 1, 0, 1, 14'h28, 0, 0, 0, 1));
        do_cycle(idle);

        // Reset between acceptance and response: response dropped, counter cleared.
        drive(mk(1, 14'd3, 1, 0, 1, 14'h30, 0, 0, 0, 1));
        #2;
        chk("pre_rst_a_ready", VW'(a_ready), '0);
        chk("pre_rst_b_ready", VW'(b_ready), VW'(1'b1));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_b_rvalid", VW'(b_rvalid), '0);
        chk("midrst_b_rdata", b_rdata, '0);
        chk("midrst_a_rdata", VW'(a_rdata), '0);
        chk("midrst_a_ready", VW'(a_ready), '0);
        qa.delete();
        qb.delete();
        last_a = '0;
        last_b = '0;
        repeat (2) @(posedge clk);
        #1;
        drive(idle);
        rst_n = 1'b1;
        do_cycle(idle);
        do_cycle(idle);
        for (int i = 0; i < 4; i++)
            do_cycle(mk(1, 14'd3, 1, 0, 1, 14'h30, 0, 0, 0, 1));
        do_cycle(mk(1, 14'd3, 1, 0, 1, 14'h30, 0, 0, 1, 0));
        do_cycle(idle);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
